// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg -- shared RV32IM decode types
//
// Purpose : opcode constants, ALU / memory / branch encodings and the control
//           bundle handed from decode to execute, plus small decode helpers.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package rv_pkg;

   // Major opcodes (instr[6:0]); the low two bits are always 2'b11 for RV32.
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND,
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } alu_op_e;

   typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} mem_op_e;
   typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} mem_size_e;
   typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} branch_e;
   typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_e;
   typedef enum logic      {SRC_B_RS2, SRC_B_IMM} src_b_e;

   typedef struct packed {
      alu_op_e   alu_op;
      src_a_e    src_a;
      src_b_e    src_b;
      mem_op_e   mem_op;
      mem_size_e mem_size;
      logic      mem_unsigned;
      branch_e   branch;
      logic      jump;       // JAL/JALR: execute writes pc+4 to rd and redirects
      logic      wr_rd_en;
   } id_ctrl_t;

   localparam id_ctrl_t ID_CTRL_NOP = '{
      alu_op:       ALU_ADD,
      src_a:        SRC_A_RS1,
      src_b:        SRC_B_RS2,
      mem_op:       MEM_NONE,
      mem_size:     SIZE_W,
      mem_unsigned: 1'b0,
      branch:       BR_NONE,
      jump:         1'b0,
      wr_rd_en:     1'b0
   };

   // Base integer ALU op from funct3; alt selects SUB/SRA (instr[30]).
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic alu_op_e alu_muldiv(input logic [2:0] f3);
      alu_op_e op;
      case (f3)
         3'b000:  op = ALU_MUL;
         3'b001:  op = ALU_MULH;
         3'b010:  op = ALU_MULHSU;
         3'b011:  op = ALU_MULHU;
         3'b100:  op = ALU_DIV;
         3'b101:  op = ALU_DIVU;
         3'b110:  op = ALU_REM;
         default: op = ALU_REMU;
      endcase
      return op;
   endfunction

   function automatic mem_size_e mem_size_from_f3(input logic [1:0] f3_lo);
      mem_size_e sz;
      case (f3_lo)
         2'b00:   sz = SIZE_B;
         2'b01:   sz = SIZE_H;
         default: sz = SIZE_W;
      endcase
      return sz;
   endfunction

   function automatic branch_e branch_from_f3(input logic [2:0] f3);
      branch_e br;
      case (f3)
         3'b000:  br = BR_EQ;
         3'b001:  br = BR_NE;
         3'b100:  br = BR_LT;
         3'b101:  br = BR_GE;
         3'b110:  br = BR_LTU;
         3'b111:  br = BR_GEU;
         default: br = BR_NONE;
      endcase
      return br;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen -- RV32 immediate extraction (combinational)
//
// Purpose : picks the I/S/B/U/J immediate format from the opcode and returns
//           it sign-extended from instr[31]. Non-immediate opcodes give 0.
// Ports   : instr  in  32  instruction word
//           imm    out 32  sign-extended immediate
// Note    : shift-immediates keep funct7 in imm[11:5]; execute uses imm[4:0].
// ---------------------------------------------------------------------------
module imm_gen
   import rv_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   always_comb begin
      imm = '0;
      case (instr[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR:
            imm = {{20{instr[31]}}, instr[31:20]};
         OPC_STORE:
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm = {instr[31:12], 12'b0};
         OPC_JAL:
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

// File: rtl/instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode -- RV32IM decode stage
//
// Purpose : accepts fetched instructions on a valid/ready handshake, drives the
//           register file read ports in the accept cycle, and registers the
//           decoded control bundle so it meets the regfile's registered read
//           data in execute. Handles load-use bubbles, flush and illegal ops.
// Ports   : clk, reset (sync, active-low)
//           if_valid/if_ready/if_instr/if_pc    fetch handshake
//           flush                               branch redirect
//           ex_ready, ex_load_pending, ex_rd_address   execute status
//           rd_rs1_en/rs1_address/rd_rs2_en/rs2_address/stall_reg_rd  regfile
//           id_valid/id_pc/id_ctrl/id_imm/id_rd_address/id_illegal    to execute
// ---------------------------------------------------------------------------
module instr_decode
   import rv_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned SUPPORT_M = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   input  logic            flush,
   input  logic            ex_ready,
   input  logic            ex_load_pending,
   input  logic [4:0]      ex_rd_address,
   output logic            rd_rs1_en,
   output logic [4:0]      rs1_address,
   output logic            rd_rs2_en,
   output logic [4:0]      rs2_address,
   output logic            stall_reg_rd,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output id_ctrl_t        id_ctrl,
   output logic [31:0]     id_imm,
   output logic [4:0]      id_rd_address,
   output logic            id_illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [31:0] dec_imm;
   id_ctrl_t    dec_ctrl;
   logic        dec_illegal;
   logic        uses_rs1;
   logic        uses_rs2;
   logic        hazard;
   logic        accept;

   logic            id_valid_reg;
   logic [XLEN-1:0] id_pc_reg;
   id_ctrl_t        id_ctrl_reg;
   logic [31:0]     id_imm_reg;
   logic [4:0]      id_rd_address_reg;
   logic            id_illegal_reg;

   assign opcode = if_instr[6:0];
   assign funct3 = if_instr[14:12];
   assign funct7 = if_instr[31:25];
   assign rd     = if_instr[11:7];

   imm_gen u_imm_gen (
      .instr (if_instr),
      .imm   (dec_imm)
   );

   // Main decode. Illegal encodings fall back to the NOP bundle so execute
   // sees no write-back and no memory access, only the illegal flag.
   always_comb begin
      dec_ctrl    = ID_CTRL_NOP;
      dec_illegal = 1'b0;
      uses_rs1    = 1'b1;
      uses_rs2    = 1'b0;
      case (opcode)
         OPC_OP: begin
            uses_rs2          = 1'b1;
            dec_ctrl.wr_rd_en = 1'b1;
            if (funct7 == F7_BASE)
               dec_ctrl.alu_op = alu_from_f3(funct3, 1'b0);
            else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
               dec_ctrl.alu_op = alu_from_f3(funct3, 1'b1);
            else if (funct7 == F7_MULDIV && SUPPORT_M != 0)
               dec_ctrl.alu_op = alu_muldiv(funct3);
            else
               dec_illegal = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_ctrl.src_b    = SRC_B_IMM;
            dec_ctrl.wr_rd_en = 1'b1;
            // instr[30] is an immediate bit for ADDI etc.; only SRAI uses it as alt
            dec_ctrl.alu_op   = alu_from_f3(funct3, funct3 == 3'b101 && if_instr[30]);
            if (funct3 == 3'b001 && funct7 != F7_BASE)
               dec_illegal = 1'b1;
            if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)
               dec_illegal = 1'b1;
         end
         OPC_LOAD: begin
            dec_ctrl.src_b        = SRC_B_IMM;
            dec_ctrl.mem_op       = MEM_LOAD;
            dec_ctrl.mem_size     = mem_size_from_f3(funct3[1:0]);
            dec_ctrl.mem_unsigned = funct3[2];
            dec_ctrl.wr_rd_en     = 1'b1;
            if (funct3[1:0] == 2'b11 || funct3 == 3'b110)
               dec_illegal = 1'b1;
         end
         OPC_STORE: begin
            uses_rs2          = 1'b1;
            dec_ctrl.src_b    = SRC_B_IMM;
            dec_ctrl.mem_op   = MEM_STORE;
            dec_ctrl.mem_size = mem_size_from_f3(funct3[1:0]);
            if (funct3[2] || funct3[1:0] == 2'b11)
               dec_illegal = 1'b1;
         end
         OPC_BRANCH: begin
            uses_rs2        = 1'b1;
            dec_ctrl.alu_op = ALU_SUB;
            dec_ctrl.branch = branch_from_f3(funct3);
            if (funct3 == 3'b010 || funct3 == 3'b011)
               dec_illegal = 1'b1;
         end
         OPC_JAL: begin
            uses_rs1          = 1'b0;
            dec_ctrl.src_a    = SRC_A_PC;
            dec_ctrl.src_b    = SRC_B_IMM;
            dec_ctrl.jump     = 1'b1;
            dec_ctrl.wr_rd_en = 1'b1;
         end
         OPC_JALR: begin
            dec_ctrl.src_b    = SRC_B_IMM;
            dec_ctrl.jump     = 1'b1;
            dec_ctrl.wr_rd_en = 1'b1;
            if (funct3 != 3'b000)
               dec_illegal = 1'b1;
         end
         OPC_LUI: begin
            uses_rs1          = 1'b0;
            dec_ctrl.src_a    = SRC_A_ZERO;
            dec_ctrl.src_b    = SRC_B_IMM;
            dec_ctrl.wr_rd_en = 1'b1;
         end
         OPC_AUIPC: begin
            uses_rs1          = 1'b0;
            dec_ctrl.src_a    = SRC_A_PC;
            dec_ctrl.src_b    = SRC_B_IMM;
            dec_ctrl.wr_rd_en = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
      if (rd == 5'd0)
         dec_ctrl.wr_rd_en = 1'b0;
      if (dec_illegal)
         dec_ctrl = ID_CTRL_NOP;
   end

   // Regfile read ports are driven straight from fetch so read data lands
   // in the same cycle the registered bundle reaches execute.
   assign rs1_address  = if_instr[19:15];
   assign rs2_address  = if_instr[24:20];
   assign rd_rs1_en    = if_valid && uses_rs1;
   assign rd_rs2_en    = if_valid && uses_rs2;
   assign stall_reg_rd = id_valid_reg && !ex_ready;

   // x0 is never a real load destination, so it cannot create a hazard.
   assign hazard = ex_load_pending && (ex_rd_address != 5'd0) &&
                   ((uses_rs1 && rs1_address == ex_rd_address) ||
                    (uses_rs2 && rs2_address == ex_rd_address));

   assign if_ready = !stall_reg_rd && !hazard && !flush;
   assign accept   = if_valid && if_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         id_valid_reg      <= 1'b0;
         id_pc_reg         <= '0;
         id_ctrl_reg       <= ID_CTRL_NOP;
         id_imm_reg        <= '0;
         id_rd_address_reg <= '0;
         id_illegal_reg    <= 1'b0;
      end else if (flush) begin
         id_valid_reg <= 1'b0;
      end else if (stall_reg_rd) begin
         id_valid_reg <= id_valid_reg;   // hold the whole bundle
      end else if (accept) begin
         id_valid_reg      <= 1'b1;
         id_pc_reg         <= if_pc;
         id_ctrl_reg       <= dec_ctrl;
         id_imm_reg        <= dec_imm;
         id_rd_address_reg <= rd;
         id_illegal_reg    <= dec_illegal;
      end else begin
         // execute consumed the bundle (or a hazard bubble): nothing new
         id_valid_reg <= 1'b0;
      end
   end

   assign id_valid      = id_valid_reg;
   assign id_pc         = id_pc_reg;
   assign id_ctrl       = id_ctrl_reg;
   assign id_imm        = id_imm_reg;
   assign id_rd_address = id_rd_address_reg;
   assign id_illegal    = id_illegal_reg;

endmodule
